// File: rtl/core_pkg.sv
// Shared core-wide constants and types: instruction ID space for in-flight vector instructions.
package core_pkg;

    localparam int unsigned InsnIDNum = 8;

    typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

endpackage

// File: rtl/retire_queue.sv
// In-order retirement tracker: allocates instruction IDs at issue, records out-of-order
// completions, and offers the oldest outstanding instruction to the scalar core once it is done.
module retire_queue
    import core_pkg::*;
#(
    parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     issue_valid_i,
    output logic     issue_ready_o,
    output insn_id_t issue_id_o,
    input  logic     done_i,
    input  insn_id_t done_insn_id_i,
    input  logic     done_illegal_i,
    output logic     retire_valid_o,
    input  logic     retire_ready_i,
    output insn_id_t retire_id_o,
    output logic     retire_illegal_o,
    output logic     empty_o
);

    localparam int unsigned CntW = $clog2(InsnIDNum) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(InsnIDNum);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // ready/valid outputs depend only on registered state, never on the partner's inputs.
    insn_id_t               r_head;
    insn_id_t               r_tail;
    logic [CntW-1:0]        r_count;
    logic [InsnIDNum-1:0]   r_done;
    logic [InsnIDNum-1:0]   r_illegal;

    logic                   w_issue;
    logic                   w_retire;
    insn_id_t               w_done_offset;
    logic                   w_done_outstanding;
    logic                   w_done_accept;

    assign issue_ready_o    = (r_count != FullCnt);
    assign issue_id_o       = r_tail;
    assign retire_valid_o   = (r_count != '0) && r_done[r_head];
    assign retire_id_o      = r_head;
    assign retire_illegal_o = r_illegal[r_head];
    assign empty_o          = (r_count == '0);

    assign w_issue  = issue_valid_i && issue_ready_o;
    assign w_retire = retire_valid_o && retire_ready_i;

    // An ID is outstanding when its distance from the head (modulo the ID space) is below count.
    assign w_done_offset      = done_insn_id_i - r_head;
    assign w_done_outstanding = ({1'b0, w_done_offset} < r_count);
    assign w_done_accept      = done_i && w_done_outstanding;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_done    <= '0;
            r_illegal <= '0;
        end else begin
            if (w_retire) begin
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + insn_id_t'(1);
            end
            if (w_issue) begin
                r_done[r_tail]    <= 1'b0;
                r_illegal[r_tail] <= 1'b0;
                r_tail            <= r_tail + insn_id_t'(1);
            end
            // A completion never targets the tail being issued: the tail is not outstanding
            // whenever an issue can be accepted.
            if (w_done_accept) begin
                r_done[done_insn_id_i]    <= 1'b1;
                r_illegal[done_insn_id_i] <= done_illegal_i;
            end
            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_done_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_ni) done_i |-> w_done_outstanding
    ) else $warning("retire_queue: done_i for ID %0d not outstanding, ignored", done_insn_id_i);
`endif

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue with InsnIDNum=8: ordering, full/no-bypass, wrap, illegal flag,
// stall stability, spurious completion and asynchronous reset.
module tb_retire_queue;
    import core_pkg::*;

    logic     clk_i;
    logic     rst_ni;
    logic     issue_valid_i;
    logic     issue_ready_o;
    insn_id_t issue_id_o;
    logic     done_i;
    insn_id_t done_insn_id_i;
    logic     done_illegal_i;
    logic     retire_valid_o;
    logic     retire_ready_i;
    insn_id_t retire_id_o;
    logic     retire_illegal_o;
    logic     empty_o;

    int n_checks;
    int n_pass;

    retire_queue #(.InsnIDNum(8)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_id_o       (issue_id_o),
        .done_i           (done_i),
        .done_insn_id_i   (done_insn_id_i),
        .done_illegal_i   (done_illegal_i),
        .retire_valid_o   (retire_valid_o),
        .retire_ready_i   (retire_ready_i),
        .retire_id_o      (retire_id_o),
        .retire_illegal_o (retire_illegal_o),
        .empty_o          (empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i  = 1'b0;
        done_i         = 1'b0;
        done_insn_id_i = '0;
        done_illegal_i = 1'b0;
        retire_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic set_done(input int id, input logic ill);
        done_i         = 1'b1;
        done_insn_id_i = insn_id_t'(id);
        done_illegal_i = ill;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (issue_ready_o !== 1'b1) $display("FAIL rst_issue_ready got %b exp 1", issue_ready_o); else n_pass++;
        n_checks++; if (issue_id_o !== 3'd0) $display("FAIL rst_issue_id got %0d exp 0", issue_id_o); else n_pass++;
        n_checks++; if (retire_valid_o !== 1'b0) $display("FAIL rst_retire_valid got %b exp 0", retire_valid_o); else n_pass++;
        n_checks++; if (retire_id_o !== 3'd0) $display("FAIL rst_retire_id got %0d exp 0", retire_id_o); else n_pass++;
        n_checks++; if (retire_illegal_o !== 1'b0) $display("FAIL rst_retire_illegal got %b exp 0", retire_illegal_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty_o); else n_pass++;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_out_of_order();
        do_reset();
        issue_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (issue_id_o !== insn_id_t'(k)) $display("FAIL ooo_issue_id got %0d exp %0d", issue_id_o, k); else n_pass++;
            step();
        end
        issue_valid_i = 1'b0;
        set_done(2, 1'b0);
        step();
        set_done(0, 1'b0);
        n_checks++; if (retire_valid_o !== 1'b0) $display("FAIL ooo_hold_id2 got %b exp 0", retire_valid_o); else n_pass++;
        step();
        set_done(1, 1'b0);
        n_checks++; if (retire_valid_o !== 1'b1) $display("FAIL ooo_valid0 got %b exp 1", retire_valid_o); else n_pass++;
        n_checks++; if (retire_id_o !== 3'd0) $display("FAIL ooo_id0 got %0d exp 0", retire_id_o); else n_pass++;
        retire_ready_i = 1'b1;
        step();
        done_i = 1'b0;
        n_checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd1) $display("FAIL ooo_id1 got v=%b id=%0d exp v=1 id=1", retire_valid_o, retire_id_o); else n_pass++;
        step();
        n_checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd2) $display("FAIL ooo_id2 got v=%b id=%0d exp v=1 id=2", retire_valid_o, retire_id_o); else n_pass++;
        step();
        retire_ready_i = 1'b0;
        n_checks++; if (retire_valid_o !== 1'b0 || empty_o !== 1'b1) $display("FAIL ooo_drained got v=%b empty=%b exp v=0 empty=1", retire_valid_o, empty_o); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        issue_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (issue_ready_o !== 1'b1 || issue_id_o !== insn_id_t'(k)) $display("FAIL full_fill got rdy=%b id=%0d exp rdy=1 id=%0d", issue_ready_o, issue_id_o, k); else n_pass++;
            step();
        end
        set_done(0, 1'b0);
        n_checks++; if (issue_ready_o !== 1'b0 || empty_o !== 1'b0) $display("FAIL full_ready got rdy=%b empty=%b exp rdy=0 empty=0", issue_ready_o, empty_o); else n_pass++;
        step();
        done_i = 1'b0;
        n_checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd0 || issue_ready_o !== 1'b0) $display("FAIL full_head got v=%b id=%0d rdy=%b exp v=1 id=0 rdy=0", retire_valid_o, retire_id_o, issue_ready_o); else n_pass++;
        retire_ready_i = 1'b1;
        step();
        retire_ready_i = 1'b0;
        n_checks++; if (issue_ready_o !== 1'b1 || issue_id_o !== 3'd0) $display("FAIL full_no_bypass got rdy=%b id=%0d exp rdy=1 id=0", issue_ready_o, issue_id_o); else n_pass++;
        n_checks++; if (retire_valid_o !== 1'b0 || retire_id_o !== 3'd1) $display("FAIL full_head1 got v=%b id=%0d exp v=0 id=1", retire_valid_o, retire_id_o); else n_pass++;
        step();
        issue_valid_i = 1'b0;
        n_checks++; if (issue_ready_o !== 1'b0 || issue_id_o !== 3'd1) $display("FAIL full_refill got rdy=%b id=%0d exp rdy=0 id=1", issue_ready_o, issue_id_o); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            issue_valid_i = 1'b1;
            n_checks++; if (issue_id_o !== insn_id_t'(k % 8)) $display("FAIL wrap_issue_id got %0d exp %0d", issue_id_o, k % 8); else n_pass++;
            step();
            issue_valid_i = 1'b0;
            set_done(k % 8, 1'b0);
            step();
            done_i = 1'b0;
            n_checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== insn_id_t'(k % 8)) $display("FAIL wrap_retire got v=%b id=%0d exp v=1 id=%0d", retire_valid_o, retire_id_o, k % 8); else n_pass++;
            retire_ready_i = 1'b1;
            step();
            retire_ready_i = 1'b0;
        end
        n_checks++; if (empty_o !== 1'b1 || issue_id_o !== 3'd2) $display("FAIL wrap_end got empty=%b id=%0d exp empty=1 id=2", empty_o, issue_id_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_valid_i = 1'b1;
        step();
        issue_valid_i = 1'b0;
        set_done(0, 1'b0);
        step();
        done_i = 1'b0;
        issue_valid_i  = 1'b1;
        retire_ready_i = 1'b1;
        n_checks++; if (issue_id_o !== 3'd1 || retire_valid_o !== 1'b1 || retire_id_o !== 3'd0) $display("FAIL b2b_pre got iid=%0d v=%b rid=%0d exp iid=1 v=1 rid=0", issue_id_o, retire_valid_o, retire_id_o); else n_pass++;
        step();
        issue_valid_i  = 1'b0;
        retire_ready_i = 1'b0;
        n_checks++; if (issue_id_o !== 3'd2 || retire_id_o !== 3'd1 || retire_valid_o !== 1'b0 || empty_o !== 1'b0) $display("FAIL b2b_post got iid=%0d rid=%0d v=%b empty=%b exp iid=2 rid=1 v=0 empty=0", issue_id_o, retire_id_o, retire_valid_o, empty_o); else n_pass++;
        set_done(1, 1'b0);
        step();
        done_i = 1'b0;
        retire_ready_i = 1'b1;
        step();
        retire_ready_i = 1'b0;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL b2b_count got empty=%b exp 1", empty_o); else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        issue_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) step();
        issue_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_done(k, (k == 3));
            step();
        end
        done_i = 1'b0;
        retire_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== insn_id_t'(k) || retire_illegal_o !== (k == 3)) $display("FAIL illegal_retire got v=%b id=%0d ill=%b exp v=1 id=%0d ill=%b", retire_valid_o, retire_id_o, retire_illegal_o, k, (k == 3)); else n_pass++;
            step();
        end
        retire_ready_i = 1'b0;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL illegal_empty got %b exp 1", empty_o); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        issue_valid_i = 1'b1;
        step();
        step();
        issue_valid_i = 1'b0;
        set_done(0, 1'b1);
        step();
        done_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) set_done(6, 1'b1);
            else done_i = 1'b0;
            n_checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd0 || retire_illegal_o !== 1'b1) $display("FAIL stall_hold got v=%b id=%0d ill=%b exp v=1 id=0 ill=1", retire_valid_o, retire_id_o, retire_illegal_o); else n_pass++;
            step();
        end
        done_i = 1'b0;
        n_checks++; if (issue_id_o !== 3'd2 || issue_ready_o !== 1'b1) $display("FAIL stall_spurious got iid=%0d rdy=%b exp iid=2 rdy=1", issue_id_o, issue_ready_o); else n_pass++;
        retire_ready_i = 1'b1;
        step();
        retire_ready_i = 1'b0;
        n_checks++; if (retire_valid_o !== 1'b0 || retire_id_o !== 3'd1 || empty_o !== 1'b0 || issue_id_o !== 3'd2) $display("FAIL stall_after got v=%b rid=%0d empty=%b iid=%0d exp v=0 rid=1 empty=0 iid=2", retire_valid_o, retire_id_o, empty_o, issue_id_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) step();
        issue_valid_i = 1'b0;
        set_done(0, 1'b0);
        step();
        done_i = 1'b0;
        n_checks++; if (retire_valid_o !== 1'b1 || empty_o !== 1'b0) $display("FAIL rmid_pre got v=%b empty=%b exp v=1 empty=0", retire_valid_o, empty_o); else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (empty_o !== 1'b1 || retire_valid_o !== 1'b0) $display("FAIL rmid_async got empty=%b v=%b exp empty=1 v=0", empty_o, retire_valid_o); else n_pass++;
        step();
        rst_ni = 1'b1;
        n_checks++; if (issue_id_o !== 3'd0 || issue_ready_o !== 1'b1) $display("FAIL rmid_release got iid=%0d rdy=%b exp iid=0 rdy=1", issue_id_o, issue_ready_o); else n_pass++;
        retire_ready_i = 1'b1;
        step();
        step();
        retire_ready_i = 1'b0;
        n_checks++; if (retire_valid_o !== 1'b0 || empty_o !== 1'b1 || retire_id_o !== 3'd0) $display("FAIL rmid_discard got v=%b empty=%b rid=%0d exp v=0 empty=1 rid=0", retire_valid_o, empty_o, retire_id_o); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_out_of_order();
        test_full();
        test_wrap();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/retire_queue.md
RETIRE_QUEUE -- requirements
Module: retire_queue

Interface
REQ-001 Parameter InsnIDNum, default from shared package (8), number of in-flight instruction IDs; power of two, >=2.
REQ-002 clk_i  input  1  clock, all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 issue_valid_i  input  1  dispatcher requests an ID for a new vector instruction.
REQ-005 issue_ready_o  output  1  an ID is free; issue accepted when issue_valid_i && issue_ready_o.
REQ-006 issue_id_o  output  insn_id_t  ID allocated to the instruction accepted this cycle.
REQ-007 done_i  input  1  completion event from commit controller.
REQ-008 done_insn_id_i  input  insn_id_t  ID of the completing instruction.
REQ-009 done_illegal_i  input  1  completing instruction was illegal; qualified by done_i.
REQ-010 retire_valid_o  output  1  head instruction is complete and offered to scalar core.
REQ-011 retire_ready_i  input  1  scalar core accepts retirement.
REQ-012 retire_id_o  output  insn_id_t  ID of head instruction.
REQ-013 retire_illegal_o  output  1  head instruction completed as illegal.
REQ-014 empty_o  output  1  no outstanding instructions.

Function
REQ-015 Block SHALL keep head pointer, tail pointer (insn_id_t, wrap modulo InsnIDNum), occupancy count (0..InsnIDNum), per-ID done bit and illegal bit.
REQ-016 issue_id_o SHALL equal tail pointer; issue_ready_o SHALL equal (count < InsnIDNum), derived from registered state only.
REQ-017 Accepted issue SHALL increment tail (wrapping InsnIDNum-1 -> 0), clear done/illegal bits of that ID, increment count.
REQ-018 done_i SHALL set done bit of done_insn_id_i and set its illegal bit to done_illegal_i, next edge.
REQ-019 done_i for an ID not outstanding SHALL be ignored (state unchanged); assertion flags it in simulation.
REQ-020 retire_valid_o SHALL equal (count != 0) && done bit at head, from registers only; minimum latency done_i -> retire_valid_o = 1 cycle.
REQ-021 retire_id_o = head pointer, retire_illegal_o = illegal bit at head; both stable while retire_valid_o && !retire_ready_i.
REQ-022 Retire handshake SHALL clear head done bit, increment head (wrapping), decrement count.
REQ-023 Retirement SHALL be strictly in issue order; out-of-order done events are held until all older IDs retire.
REQ-024 Simultaneous issue and retire SHALL leave count unchanged; both pointers advance.
REQ-025 When full (count = InsnIDNum), issue SHALL be refused even if a retire occurs in the same cycle (no bypass).
REQ-026 done_i for head ID in same cycle as retire handshake cannot occur (head already done); no special handling.
REQ-027 empty_o SHALL equal (count == 0).

Reset
REQ-028 On rst_ni low: head=0, tail=0, count=0, all done/illegal bits 0, immediately (asynchronous).
REQ-029 Reset outputs: issue_ready_o=1, issue_id_o=0, retire_valid_o=0, retire_id_o=0, retire_illegal_o=0, empty_o=1.
REQ-030 Reset mid-operation SHALL discard all outstanding IDs; no retire issued for them after release.

Structure
REQ-031 InsnIDNum and insn_id_t SHALL come from core_pkg; no new package types required.
REQ-032 Single flat module; no sub-module; count width $clog2(InsnIDNum)+1.

Verification (InsnIDNum=8)
REQ-033 Issue 3 (IDs 0,1,2), done 2 then 0 then 1 on consecutive cycles -> retire IDs 0,1,2 in order, first retire_valid_o one cycle after done of ID 0.
REQ-034 Issue 8 without done -> issue_ready_o=0 at count 8; done 0 + retire same cycle as issue_valid_i -> issue refused that cycle, accepted next with issue_id_o=0.
REQ-035 Issue 10 total with retires interleaved -> issue_id_o wraps 7 -> 0 -> 1; retire order 0..7,0,1.
REQ-036 done ID 3 with done_illegal_i=1 (IDs 0..3 outstanding, 0..2 done) -> retire ID 3 with retire_illegal_o=1, others 0.
REQ-037 retire_ready_i held low 4 cycles with retire_valid_o=1 -> retire_id_o/retire_illegal_o unchanged; spurious done for ID 6 (not outstanding) -> no state change.
REQ-038 Assert rst_ni low with 5 outstanding -> empty_o=1, retire_valid_o=0 immediately; after release issue_id_o=0.
